program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 37 +++
 tb/tb_program_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter register for an instruction fetch stage: holds the full PC,
// exposes a truncated instruction-memory address, PC+4 and a misalignment flag.
module program_counter #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 13,
  parameter logic [DATA_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcWrite,
  input  logic [DATA_W-1:0] pcInput,
  output logic [ADDR_W-1:0] pcOutput,
  output logic [DATA_W-1:0] pcFull,
  output logic [DATA_W-1:0] pcPlus4,
  output logic              pcMisaligned
);

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  logic [DATA_W-1:0] pc_q;

  // Asynchronous clear wins over any load that would land in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (pcWrite) begin
      pc_q <= pcInput;
    end
  end

  // Every output is a pure function of the register, never of pcInput/pcWrite.
  assign pcFull       = pc_q;
  assign pcOutput     = pc_q[ADDR_W-1:0];
  assign pcPlus4      = pc_q + PC_STEP;
  assign pcMisaligned = |pc_q[1:0];

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter with default parameters.
module tb_program_counter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;

  logic              clk;
  logic              reset;
  logic              pcWrite;
  logic [DATA_W-1:0] pcInput;
  logic [ADDR_W-1:0] pcOutput;
  logic [DATA_W-1:0] pcFull;
  logic [DATA_W-1:0] pcPlus4;
  logic              pcMisaligned;

  int checks = 0;
  int errors = 0;

  program_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcWrite      (pcWrite),
    .pcInput      (pcInput),
    .pcOutput     (pcOutput),
    .pcFull       (pcFull),
    .pcPlus4      (pcPlus4),
    .pcMisaligned (pcMisaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs mid-cycle, then sample 1 time unit after the following rising edge.
  task automatic drive(input logic wr, input logic [DATA_W-1:0] din);
    @(negedge clk);
    pcWrite = wr;
    pcInput = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if (pcOutput !== 13'h0) begin errors++; $display("FAIL reset_pcOutput got %h expected %h", pcOutput, 13'h0); end
    checks++; if (pcFull !== 32'h0) begin errors++; $display("FAIL reset_pcFull got %h expected %h", pcFull, 32'h0); end
    checks++; if (pcPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pcPlus4 got %h expected %h", pcPlus4, 32'h4); end
    checks++; if (pcMisaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b expected %b", pcMisaligned, 1'b0); end
    // pcWrite must be ignored while reset is held
    pcWrite = 1'b1;
    pcInput = 32'hDEADBEEF;
    tick();
    checks++; if (pcFull !== 32'h0) begin errors++; $display("FAIL reset_ignores_write got %h expected %h", pcFull, 32'h0); end
    $display("txn reset: pcFull=%h pcPlus4=%h", pcFull, pcPlus4);
    @(negedge clk);
    pcWrite = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic test_hold();
    drive(1'b0, 32'h51162A88);
    tick();
    checks++; if (pcOutput !== 13'h0) begin errors++; $display("FAIL hold_from_reset_pcOutput got %h expected %h", pcOutput, 13'h0); end
    checks++; if (pcFull !== 32'h0) begin errors++; $display("FAIL hold_from_reset_pcFull got %h expected %h", pcFull, 32'h0); end
    $display("txn hold: pcInput=%h pcFull=%h", pcInput, pcFull);
  endtask

  task automatic test_load();
    drive(1'b1, 32'h51162A98);
    tick();
    checks++; if (pcFull !== 32'h51162A98) begin errors++; $display("FAIL load1_pcFull got %h expected %h", pcFull, 32'h51162A98); end
    checks++; if (pcOutput !== 13'h0A98) begin errors++; $display("FAIL load1_pcOutput got %h expected %h", pcOutput, 13'h0A98); end
    checks++; if (pcPlus4 !== 32'h51162A9C) begin errors++; $display("FAIL load1_pcPlus4 got %h expected %h", pcPlus4, 32'h51162A9C); end
    checks++; if (pcMisaligned !== 1'b0) begin errors++; $display("FAIL load1_misaligned got %b expected %b", pcMisaligned, 1'b0); end
    $display("txn load: pcInput=%h pcFull=%h pcOutput=%h", pcInput, pcFull, pcOutput);
    drive(1'b1, 32'h51162A8C);
    tick();
    checks++; if (pcOutput !== 13'h0A8C) begin errors++; $display("FAIL load2_pcOutput got %h expected %h", pcOutput, 13'h0A8C); end
    checks++; if (pcFull !== 32'h51162A8C) begin errors++; $display("FAIL load2_pcFull got %h expected %h", pcFull, 32'h51162A8C); end
    $display("txn load: pcInput=%h pcFull=%h pcOutput=%h", pcInput, pcFull, pcOutput);
  endtask

  task automatic test_hold_loaded();
    drive(1'b0, 32'hD3162A88);
    tick();
    checks++; if (pcFull !== 32'h51162A8C) begin errors++; $display("FAIL hold_pcFull got %h expected %h", pcFull, 32'h51162A8C); end
    checks++; if (pcOutput !== 13'h0A8C) begin errors++; $display("FAIL hold_pcOutput got %h expected %h", pcOutput, 13'h0A8C); end
    // Input changes between edges must not leak to the outputs
    pcWrite = 1'b1;
    pcInput = 32'h00000010;
    #2;
    checks++; if (pcFull !== 32'h51162A8C) begin errors++; $display("FAIL between_edges_pcFull got %h expected %h", pcFull, 32'h51162A8C); end
    $display("txn hold: pcInput=%h pcFull=%h", pcInput, pcFull);
    @(negedge clk);
    pcWrite = 1'b0;
  endtask

  task automatic test_misaligned_wrap();
    drive(1'b1, 32'h51162A9B);
    tick();
    checks++; if (pcOutput !== 13'h0A9B) begin errors++; $display("FAIL misaligned_pcOutput got %h expected %h", pcOutput, 13'h0A9B); end
    checks++; if (pcMisaligned !== 1'b1) begin errors++; $display("FAIL misaligned_flag got %b expected %b", pcMisaligned, 1'b1); end
    checks++; if (pcFull !== 32'h51162A9B) begin errors++; $display("FAIL misaligned_pcFull got %h expected %h", pcFull, 32'h51162A9B); end
    $display("txn misaligned: pcFull=%h flag=%b", pcFull, pcMisaligned);
    drive(1'b1, 32'hFFFFFFFC);
    tick();
    checks++; if (pcOutput !== 13'h1FFC) begin errors++; $display("FAIL wrap_pcOutput got %h expected %h", pcOutput, 13'h1FFC); end
    checks++; if (pcPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcPlus4 got %h expected %h", pcPlus4, 32'h0); end
    checks++; if (pcMisaligned !== 1'b0) begin errors++; $display("FAIL wrap_misaligned got %b expected %b", pcMisaligned, 1'b0); end
    $display("txn wrap: pcFull=%h pcPlus4=%h", pcFull, pcPlus4);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h12345678);
    tick();
    checks++; if (pcFull !== 32'h12345678) begin errors++; $display("FAIL pre_reset_pcFull got %h expected %h", pcFull, 32'h12345678); end
    pcInput = 32'hABCD0004;
    #1 reset = 1'b0;
    #1;
    checks++; if (pcFull !== 32'h0) begin errors++; $display("FAIL async_reset_pcFull got %h expected %h", pcFull, 32'h0); end
    checks++; if (pcOutput !== 13'h0) begin errors++; $display("FAIL async_reset_pcOutput got %h expected %h", pcOutput, 13'h0); end
    checks++; if (pcPlus4 !== 32'h4) begin errors++; $display("FAIL async_reset_pcPlus4 got %h expected %h", pcPlus4, 32'h4); end
    tick();
    checks++; if (pcFull !== 32'h0) begin errors++; $display("FAIL reset_overrides_load got %h expected %h", pcFull, 32'h0); end
    $display("txn async_reset: pcFull=%h", pcFull);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (pcFull !== 32'hABCD0004) begin errors++; $display("FAIL post_release_load got %h expected %h", pcFull, 32'hABCD0004); end
    checks++; if (pcOutput !== 13'h0004) begin errors++; $display("FAIL post_release_pcOutput got %h expected %h", pcOutput, 13'h0004); end
    $display("txn release: pcFull=%h pcOutput=%h", pcFull, pcOutput);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h00000100);
    tick();
    checks++; if (pcFull !== 32'h00000100) begin errors++; $display("FAIL b2b_1 got %h expected %h", pcFull, 32'h00000100); end
    pcInput = 32'h00000104;
    tick();
    checks++; if (pcFull !== 32'h00000104) begin errors++; $display("FAIL b2b_2 got %h expected %h", pcFull, 32'h00000104); end
    checks++; if (pcPlus4 !== 32'h00000108) begin errors++; $display("FAIL b2b_pcPlus4 got %h expected %h", pcPlus4, 32'h00000108); end
    $display("txn back_to_back: pcFull=%h pcPlus4=%h", pcFull, pcPlus4);
  endtask

  initial begin
    reset   = 1'b1;
    pcWrite = 1'b0;
    pcInput = '0;
    test_reset();
    test_hold();
    test_load();
    test_hold_loaded();
    test_misaligned_wrap();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
